// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types, constants and helpers for the UART receive path.
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_t;

  // Clocks per oversample tick, rounded to the nearest integer.
  function automatic int calc_div(input int clk_freq, input int baud, input int oversample);
    int den;
    den = baud * oversample;
    return (clk_freq + den / 2) / den;
  endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_receiver_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_receiver_if
//  Description : Serial input and received-byte strobe bundle of the UART RX.
//  Revision    : 1.0  initial release
// ============================================================================
interface uart_receiver_if;
  import uart_pkg::*;

  logic                 RxD;
  logic [DATA_BITS-1:0] data;
  logic                 valid;
  logic                 frame_err;
  logic                 busy;

  // Receiver side: samples the line, drives the byte and status strobes.
  modport master (
    input  RxD,
    output data,
    output valid,
    output frame_err,
    output busy
  );

  // Line driver / consumer side.
  modport slave (
    output RxD,
    input  data,
    input  valid,
    input  frame_err,
    input  busy
  );

endinterface : uart_receiver_if
`default_nettype wire

// File: rtl/uart_rx_tick.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_tick
//  Description : Oversample tick divider, one-clk tick every DIV clocks while
//                enabled, with a synchronous clear to re-align its phase.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx_tick #(
  parameter int DIV = 27
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int              CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = en && (cnt_q == LAST);

  // Next count: clear wins, hold at zero while disabled, wrap at DIV-1.
  always_comb begin
    cnt_d = cnt_q;
    if (clr || !en) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Divider register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : uart_rx_tick
`default_nettype wire

// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : uart_receiver
//  Description : 8N1 UART receiver. Synchronises RxD, qualifies the start bit
//                at mid-bit, samples data LSB first at mid-bit and strobes
//                valid (good stop) or frame_err (low stop) for one clock.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_receiver_if.master  rx
);

  localparam int DIV    = calc_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int SAMP_W = $clog2(OVERSAMPLE);

  localparam logic [SAMP_W-1:0] HALF_LAST = SAMP_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SAMP_W-1:0] BIT_LAST  = SAMP_W'(OVERSAMPLE - 1);
  localparam logic [2:0]        IDX_LAST  = 3'(DATA_BITS - 1);

  localparam logic [2:0] ST_IDLE  = RX_IDLE;
  localparam logic [2:0] ST_START = RX_START;
  localparam logic [2:0] ST_DATA  = RX_DATA;
  localparam logic [2:0] ST_STOP  = RX_STOP;
  localparam logic [2:0] ST_BREAK = RX_BREAK;

  generate
    if ((OVERSAMPLE % 2) != 0 || OVERSAMPLE < 8 || DIV < 1) begin : g_param_check
      $error("uart_receiver: OVERSAMPLE must be even and >= 8, and DIV >= 1");
    end
  endgenerate

  // Synchroniser and edge-detect flops.
  logic sync1_q, sync2_q, sync3_q;
  logic rxs;
  logic start_edge;

  // FSM and datapath state.
  logic [2:0]           state_q,  state_d;
  logic [SAMP_W-1:0]    samp_q,   samp_d;
  logic [2:0]           idx_q,    idx_d;
  logic [DATA_BITS-1:0] shift_q,  shift_d;
  logic [DATA_BITS-1:0] data_q,   data_d;
  logic                 valid_q,  valid_d;
  logic                 ferr_q,   ferr_d;

  logic tick;
  logic tick_en;
  logic tick_clr;

  assign rxs     = sync2_q;
  assign tick_en = (state_q != ST_IDLE);

  uart_rx_tick #(
    .DIV (DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (tick_en),
    .clr   (tick_clr),
    .tick  (tick)
  );

  // Two-stage synchroniser plus one delay stage for falling-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= IDLE_LEVEL;
      sync2_q <= IDLE_LEVEL;
      sync3_q <= IDLE_LEVEL;
    end else begin
      sync1_q <= rx.RxD;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign start_edge = (state_q == ST_IDLE) && sync3_q && !rxs;

  // Frame FSM: counts oversample ticks and samples the line at mid-bit.
  always_comb begin
    state_d  = state_q;
    samp_d   = samp_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    ferr_d   = 1'b0;
    tick_clr = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          state_d  = ST_START;
          samp_d   = '0;
          tick_clr = 1'b1;
        end
      end

      ST_START: begin
        if (tick) begin
          if (samp_q == HALF_LAST) begin
            samp_d = '0;
            if (!rxs) begin
              state_d = ST_DATA;
              idx_d   = '0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            samp_d = samp_q + SAMP_W'(1);
          end
        end
      end

      ST_DATA: begin
        if (tick) begin
          if (samp_q == BIT_LAST) begin
            samp_d         = '0;
            shift_d[idx_q] = rxs;
            if (idx_q == IDX_LAST) begin
              state_d = ST_STOP;
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end else begin
            samp_d = samp_q + SAMP_W'(1);
          end
        end
      end

      ST_STOP: begin
        if (tick) begin
          if (samp_q == BIT_LAST) begin
            samp_d = '0;
            if (rxs) begin
              data_d  = shift_q;
              valid_d = 1'b1;
              state_d = ST_IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = ST_BREAK;
            end
          end else begin
            samp_d = samp_q + SAMP_W'(1);
          end
        end
      end

      ST_BREAK: begin
        // Only a returned-high line re-arms; a held-low line is not a start.
        if (rxs) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        samp_d  = '0;
        idx_d   = '0;
      end
    endcase
  end

  // FSM, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      samp_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      samp_q  <= samp_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign rx.data      = data_q;
  assign rx.valid     = valid_q;
  assign rx.frame_err = ferr_q;
  assign rx.busy      = (state_q != ST_IDLE);

endmodule : uart_receiver
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_receiver
//  Description : Self-checking bench for uart_receiver: directed frame table,
//                glitch/break/reset sequences and randomized frames against a
//                frame-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_receiver;

  // DIV = 3, 16x oversample -> 48 clk per bit.
  localparam int  CLK_FREQ = 4_800_000;
  localparam int  BAUD     = 100_000;
  localparam int  OVS      = 16;
  localparam int  BIT_CLK  = 48;
  localparam real BIT_R    = 48.0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  uart_receiver_if rx_if ();

  uart_receiver #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OVS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rx    (rx_if)
  );

  // ---------------- strobe monitor (ring of observed events) ----------------
  logic       ev_err  [256];
  logic [7:0] ev_data [256];
  logic       ev_both [256];
  logic       ev_busy [256];
  int         ev_wr = 0;
  int         silent_changes = 0;
  logic [7:0] prev_data = 8'h00;

  always @(negedge clk) begin
    if (rx_if.valid || rx_if.frame_err) begin
      ev_err [ev_wr % 256] = rx_if.frame_err;
      ev_data[ev_wr % 256] = rx_if.data;
      ev_both[ev_wr % 256] = rx_if.valid && rx_if.frame_err;
      ev_busy[ev_wr % 256] = rx_if.busy;
      ev_wr = ev_wr + 1;
    end
    if (rst_n && (rx_if.data !== prev_data) && !rx_if.valid)
      silent_changes = silent_changes + 1;
    prev_data = rx_if.data;
  end

  // ---------------- checking helpers ----------------
  int total = 0;
  int bad   = 0;
  int rd    = 0;
  logic [7:0] last_good = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive one frame: start, 8 data LSB first, stop bit(s). A bad frame keeps
  // the line low for two further bit times, then idles high for one bit.
  task automatic send_frame(input logic [7:0] b, input int stop_bits,
                            input bit bad_stop, input real period);
    int nbits;
    int t0, t1;
    logic lvl;
    nbits = 1 + 8 + stop_bits;
    for (int i = 0; i < nbits; i++) begin
      if (i == 0)      lvl = 1'b0;
      else if (i <= 8) lvl = b[i-1];
      else             lvl = !bad_stop;
      t0 = $rtoi(i * period + 0.5);
      t1 = $rtoi((i + 1) * period + 0.5);
      rx_if.RxD = lvl;
      hold(t1 - t0);
    end
    if (bad_stop) begin
      rx_if.RxD = 1'b0;
      hold(2 * BIT_CLK);
      rx_if.RxD = 1'b1;
      hold(BIT_CLK);
    end
    rx_if.RxD = 1'b1;
  endtask

  task automatic expect_event(input string nm, input bit exp_err, input logic [7:0] exp_data);
    int n;
    n = 0;
    while (ev_wr == rd && n < 20 * BIT_CLK) begin
      @(negedge clk);
      n++;
    end
    if (ev_wr == rd) begin
      total++;
      bad++;
      $display("FAIL %s timeout: no strobe seen, required kind=%0d data=%0h", nm, exp_err, exp_data);
    end else begin
      chk({nm, "_kind"},  32'(ev_err [rd % 256]), 32'(exp_err));
      chk({nm, "_data"},  32'(ev_data[rd % 256]), 32'(exp_data));
      chk({nm, "_both"},  32'(ev_both[rd % 256]), 32'd0);
      if (!exp_err) chk({nm, "_busy"}, 32'(ev_busy[rd % 256]), 32'd0);
      rd++;
    end
  endtask

  // ---------------- directed frame table ----------------
  typedef struct {
    logic [7:0] b;
    int         stop_bits;
    bit         bad_stop;
    real        period;
    bit         exp_err;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vt [11];

  initial begin
    vt[0]  = '{8'h3C, 1, 1'b1, BIT_R,        1'b1, 8'h00};
    vt[1]  = '{8'h81, 1, 1'b0, BIT_R,        1'b0, 8'h81};
    vt[2]  = '{8'hA5, 1, 1'b0, BIT_R,        1'b0, 8'hA5};
    vt[3]  = '{8'h00, 1, 1'b0, BIT_R,        1'b0, 8'h00};
    vt[4]  = '{8'hFF, 1, 1'b0, BIT_R,        1'b0, 8'hFF};
    vt[5]  = '{8'h55, 1, 1'b0, BIT_R,        1'b0, 8'h55};
    vt[6]  = '{8'h00, 2, 1'b0, BIT_R,        1'b0, 8'h00};
    vt[7]  = '{8'hFF, 2, 1'b0, BIT_R,        1'b0, 8'hFF};
    vt[8]  = '{8'h55, 2, 1'b0, BIT_R,        1'b0, 8'h55};
    vt[9]  = '{8'hC3, 1, 1'b0, BIT_R * 0.97, 1'b0, 8'hC3};
    vt[10] = '{8'hC3, 1, 1'b0, BIT_R * 1.03, 1'b0, 8'hC3};

    rx_if.RxD = 1'b1;

    // Reset state.
    hold(3);
    chk("rst_data",  32'(rx_if.data),      32'h00);
    chk("rst_valid", 32'(rx_if.valid),     32'd0);
    chk("rst_ferr",  32'(rx_if.frame_err), 32'd0);
    chk("rst_busy",  32'(rx_if.busy),      32'd0);
    rst_n = 1'b1;
    hold(5);

    // Short low glitch: qualified away at the half-bit sample.
    rx_if.RxD = 1'b0;
    hold(10);
    rx_if.RxD = 1'b1;
    hold(2);
    chk("glitch_busy_hi", 32'(rx_if.busy), 32'd1);
    hold(30);
    chk("glitch_busy_lo", 32'(rx_if.busy), 32'd0);
    chk("glitch_no_strobe", 32'(ev_wr - rd), 32'd0);
    chk("glitch_data", 32'(rx_if.data), 32'h00);
    hold(BIT_CLK);

    // Table: back-to-back frames, 2-stop frames, framing error, baud skew.
    for (int i = 0; i < 11; i++) begin
      send_frame(vt[i].b, vt[i].stop_bits, vt[i].bad_stop, vt[i].period);
      expect_event($sformatf("vec%0d", i), vt[i].exp_err, vt[i].exp_data);
    end
    last_good = 8'hC3;

    // Randomized frames against the frame-level model.
    for (int i = 0; i < 30; i++) begin
      logic [7:0] b;
      int         sb;
      bit         bs;
      real        per;
      b   = 8'($urandom);
      sb  = 1 + int'($urandom_range(1));
      bs  = ($urandom_range(7) == 0);
      per = BIT_R * (0.98 + 0.04 * real'($urandom_range(100)) / 100.0);
      send_frame(b, sb, bs, per);
      if (bs) begin
        expect_event($sformatf("rnd%0d", i), 1'b1, last_good);
      end else begin
        expect_event($sformatf("rnd%0d", i), 1'b0, b);
        last_good = b;
      end
      hold(int'($urandom_range(20)));
    end

    // Reset in the middle of a frame, then a clean frame.
    send_frame(8'h7E, 1, 1'b0, BIT_R);
    expect_event("pre_rst", 1'b0, 8'h7E);
    fork
      send_frame(8'hF0, 1, 1'b0, BIT_R);
      begin
        hold(5 * BIT_CLK + BIT_CLK / 2);
        rst_n = 1'b0;
        #1;
        chk("midrst_data",  32'(rx_if.data),      32'h00);
        chk("midrst_valid", 32'(rx_if.valid),     32'd0);
        chk("midrst_ferr",  32'(rx_if.frame_err), 32'd0);
        chk("midrst_busy",  32'(rx_if.busy),      32'd0);
        hold(3);
        rst_n = 1'b1;
      end
    join
    hold(2 * BIT_CLK);
    chk("midrst_no_strobe", 32'(ev_wr - rd), 32'd0);
    last_good = 8'h00;
    send_frame(8'h0F, 1, 1'b0, BIT_R);
    expect_event("post_rst", 1'b0, 8'h0F);
    hold(2 * BIT_CLK);
    chk("no_extra_strobe", 32'(ev_wr - rd), 32'd0);
    chk("data_only_on_valid", 32'(silent_changes), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_uart_receiver
`default_nettype wire

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial-to-parallel UART receiver, 8N1 framing, LSB first, line idles high.
- Counterpart to the existing transmitter, which sends 8 data bits and 2 stop bits; this block needs only 1 stop bit and treats any extra stop bits as idle.
- Sits between the host serial input pin and the command parser of the frequency meter.
- Oversamples the line, qualifies start bits, samples each bit at mid-bit, and outputs one byte per frame with a single-cycle valid strobe.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD, 115200, line rate in bits/s.
- OVERSAMPLE, 16, sample ticks per bit period; must be even and at least 8.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- RxD  in  1  asynchronous serial input, idle high.
- data  out  8  last correctly framed byte; held until the next good frame.
- valid  out  1  one-clk pulse; data is new in the same cycle.
- frame_err  out  1  one-clk pulse when the stop bit is sampled low.
- busy  out  1  high whenever state is not Idle.

Behaviour:
- Reset: one clock, asynchronous active-low reset.
  - Reset values: data=8'h00, valid=0, frame_err=0, busy=0, state=Idle, sync flops=1, counters=0.
  - Reset asserted mid-frame aborts the frame immediately with no strobe.
- Synchroniser: two flops on RxD. All logic uses the second stage (rxs). Edge detection uses a third flop.
- Tick generator:
  - DIV = round(CLK_FREQ/(BAUD*OVERSAMPLE)); 27 at the defaults.
  - Emits a one-clk tick every DIV clocks.
  - Cleared on start-edge detection, so phase is re-aligned every frame.
- States:
  - Idle: on an rxs falling edge, go to Start, clear the tick and sample counters.
  - Start: after OVERSAMPLE/2 ticks, sample rxs.
    - rxs=0: go to Data, bit index=0.
    - rxs=1: false start; return to Idle with no strobe.
  - Data: every OVERSAMPLE ticks, sample rxs into shift[index], LSB first. After index 7, go to Stop.
  - Stop: after OVERSAMPLE ticks, sample rxs.
    - rxs=1: data<=shift, valid=1 for one clk, go to Idle.
    - rxs=0: frame_err=1 for one clk, data unchanged, go to Break.
  - Break: wait for rxs=1, then go to Idle. A low line is never re-armed as a new start.
  - Undefined state encodings: go to Idle.
- Latency: valid rises 1 clk after the mid-stop sample, about 9.5 bit times plus 3 clk after the RxD falling edge.
- A new start edge is accepted the cycle after returning to Idle, so back-to-back frames with 1 stop bit work.
- valid and frame_err are never high together.
- There is no ready/backpressure: the consumer must take data within one frame time, otherwise data is overwritten.
- Counters: sample counter width is clog2(OVERSAMPLE); tick divider width is clog2(DIV); bit index is 3 bits. No counter wraps outside its state.

Decomposition:
- Package uart_pkg holds:
  - rx_state_t enum: Idle, Start, Data, Stop, Break.
  - Constants DATA_BITS=8, IDLE_LEVEL=1'b1.
  - Function calc_div(clk_freq, baud, oversample).
- Sub-module uart_rx_tick: the oversample tick divider with synchronous clear. It can later be reused by a shared baud block.

Test Plan (defaults; bit period = 432 clk):
- Single frame 0xA5 at nominal baud -> exactly one valid pulse, data=8'hA5, frame_err never high, busy falls with valid.
- Low glitch on RxD of 100 clk (shorter than a half bit of 216 clk) -> no valid or frame_err; busy high for about 216 clk, then 0; data unchanged.
- Frame 0x3C with the stop bit forced low, line held low for 2 bit times, then frame 0x81 -> one frame_err pulse, data stays 8'h00 until the second frame; then valid with data=8'h81.
- Back-to-back frames 0x00, 0xFF, 0x55 with 1 stop bit, then the same bytes from the existing transmitter (2 stop bits) -> 6 valid pulses, bytes in order.
- Baud skew: sender at ±3% of BAUD sends 0xC3 -> data=8'hC3 in both cases, no frame_err.
- rst_n pulsed low at bit 4 of frame 0xF0 -> outputs take reset values at once; the next frame 0x0F gives data=8'h0F with one valid.
